// File: rtl/rv_multicycle_seq_pkg.sv
// rv_multicycle_seq_pkg: opcodes, FSM states, opcode classes, trap causes
// for the RV32I multi-cycle sequencer, plus the opcode classifier.
package rv_multicycle_seq_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_R      = 4'd0,
    CL_I      = 4'd1,
    CL_LOAD   = 4'd2,
    CL_STORE  = 4'd3,
    CL_BRANCH = 4'd4,
    CL_JAL    = 4'd5,
    CL_JALR   = 4'd6,
    CL_AUIPC  = 4'd7,
    CL_LUI    = 4'd8,
    CL_NOP    = 4'd9,
    CL_ILL    = 4'd10
  } cls_t;

  typedef enum logic [1:0] {
    TC_NONE = 2'b00,
    TC_ILL  = 2'b01,
    TC_BUS  = 2'b10
  } cause_t;

  function automatic cls_t op_class(input logic [6:0] op);
    cls_t c;
    c = CL_ILL;
    unique case (1'b1)
      (op == OP_R):      c = CL_R;
      (op == OP_I):      c = CL_I;
      (op == OP_LOAD):   c = CL_LOAD;
      (op == OP_STORE):  c = CL_STORE;
      (op == OP_BRANCH): c = CL_BRANCH;
      (op == OP_JAL):    c = CL_JAL;
      (op == OP_JALR):   c = CL_JALR;
      (op == OP_AUIPC):  c = CL_AUIPC;
      (op == OP_LUI):    c = CL_LUI;
      (op == OP_NOP):    c = CL_NOP;
      default:           c = CL_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_multicycle_seq_if.sv
// rv_multicycle_seq_if: shared memory-port handshake.
// master (sequencer) drives req/we/addr_sel; slave (memory) returns mem_ready.
interface rv_multicycle_seq_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/rv_mem_wait_timer.sv
// rv_mem_wait_timer: counts cycles a memory request waits for mem_ready.
// clr: restart count; wait_cyc: request pending, not ready; timeout: last allowed wait.
module rv_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wait_cyc,
  output logic timeout
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wait_cyc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the MEM_TIMEOUT-th consecutive wait cycle.
  assign timeout = wait_cyc && (cnt == LAST);

endmodule

// File: rtl/rv_multicycle_seq.sv
// rv_multicycle_seq: RV32I multi-cycle sequencer. Ports: clk, rst_n, run, opcode,
// br_taken, mem (handshake if), ir/pc/rf enables, instr_done, halted, trap_cause, instret.
module rv_multicycle_seq
  import rv_multicycle_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [6:0]            opcode,
  input  logic                  br_taken,
  rv_multicycle_seq_if.master   mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_sel,
  output logic                  rf_we,
  output logic                  instr_done,
  output logic                  halted,
  output logic [1:0]            trap_cause,
  output logic [CNT_W-1:0]      instret
);

  state_t st;
  state_t st_nxt;
  state_t bound;
  cls_t   cls_q;
  cls_t   dec;
  cause_t cause_q;
  cause_t cause_d;
  logic   cls_ld;
  logic   trap_ld;
  logic   req_st;
  logic   wait_cyc;
  logic   tmr_clr;
  logic   tmo;

  assign dec     = op_class(opcode);
  assign bound   = run ? ST_FETCH : ST_IDLE;
  assign req_st  = (st == ST_FETCH) || (st == ST_MEM);
  assign wait_cyc = req_st && !mem.mem_ready;
  assign tmr_clr = mem.mem_ready
                 || ((st_nxt == ST_FETCH || st_nxt == ST_MEM)
                     && st_nxt != st);

  rv_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .wait_cyc(wait_cyc),
    .timeout (tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      cls_q   <= CL_NOP;
      cause_q <= TC_NONE;
      instret <= '0;
    end else begin
      st <= st_nxt;
      if (cls_ld) cls_q <= dec;
      if (trap_ld) cause_q <= cause_d;
      if (instr_done) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    st_nxt       = st;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    rf_we        = 1'b0;
    instr_done   = 1'b0;
    cls_ld       = 1'b0;
    trap_ld      = 1'b0;
    cause_d      = TC_NONE;
    unique case (st)
      ST_IDLE: begin
        if (run) st_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem.mem_req = 1'b1;
        if (tmo) begin
          st_nxt  = ST_TRAP;
          trap_ld = 1'b1;
          cause_d = TC_BUS;
        end else if (mem.mem_ready) begin
          ir_we  = 1'b1;
          st_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_ld = 1'b1;
        if (dec == CL_NOP) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
          st_nxt     = bound;
        end else if (dec == CL_ILL) begin
          st_nxt  = ST_TRAP;
          trap_ld = 1'b1;
          cause_d = TC_ILL;
        end else begin
          st_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
          st_nxt = ST_MEM;
        end else if (cls_q == CL_BRANCH) begin
          pc_we      = 1'b1;
          pc_sel     = br_taken;
          instr_done = 1'b1;
          st_nxt     = bound;
        end else begin
          st_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = (cls_q == CL_STORE);
        if (tmo) begin
          st_nxt  = ST_TRAP;
          trap_ld = 1'b1;
          cause_d = TC_BUS;
        end else if (mem.mem_ready) begin
          if (cls_q == CL_STORE) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            st_nxt     = bound;
          end else begin
            st_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = (cls_q == CL_JAL) || (cls_q == CL_JALR);
        instr_done = 1'b1;
        st_nxt     = bound;
      end
      ST_TRAP: begin
        st_nxt = ST_TRAP;
      end
      default: begin
        st_nxt = ST_IDLE;
      end
    endcase
  end

  assign halted     = (st == ST_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv_multicycle_seq.sv
// tb_rv_multicycle_seq: table vectors, corner sequences and randomized
// instruction streams against a per-instruction schedule model.
module tb_rv_multicycle_seq;

  localparam int TO = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic br_taken = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic ir_we, pc_we, pc_sel, rf_we, instr_done, halted;
  logic [1:0] trap_cause;
  logic [CW-1:0] instret;

  rv_multicycle_seq_if mif ();

  int n_chk = 0;
  int n_err = 0;

  int m_cnt;
  bit m_halt;
  logic [1:0] m_cause;
  bit m_idle;

  typedef struct packed {
    logic req; logic we; logic asel; logic ir;
    logic pcw; logic pcs; logic rf; logic done;
  } en_t;

  typedef struct {
    string nm; logic [6:0] op; bit tk;
    int lat; bit rf; bit pcs; logic [1:0] cause;
  } vec_t;

  vec_t tab[12];
  logic [6:0] legal[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                            7'h6f, 7'h67, 7'h17, 7'h37, 7'h00};

  always #5 clk = ~clk;

  rv_multicycle_seq #(
    .MEM_TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .opcode(opcode),
    .br_taken(br_taken),
    .mem(mif),
    .ir_we(ir_we),
    .pc_we(pc_we),
    .pc_sel(pc_sel),
    .rf_we(rf_we),
    .instr_done(instr_done),
    .halted(halted),
    .trap_cause(trap_cause),
    .instret(instret)
  );

  function automatic en_t outs();
    return {mif.mem_req, mif.mem_we, mif.addr_sel, ir_we,
            pc_we, pc_sel, rf_we, instr_done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input en_t e, input string nm);
    @(negedge clk);
    chk(nm, 32'({outs(), halted, trap_cause, instret}),
        32'({e, m_halt, m_cause, 4'(m_cnt)}));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    mif.mem_ready = 1'b0;
    opcode = 7'd0;
    br_taken = 1'b0;
    m_cnt = 0;
    m_halt = 1'b0;
    m_cause = 2'b00;
    m_idle = 1'b1;
    @(negedge clk);
    chk("reset", 32'({outs(), halted, trap_cause, instret}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic trap(input logic [1:0] c);
    m_halt = 1'b1;
    m_cause = c;
    repeat (3) begin
      run = 1'($urandom);
      mif.mem_ready = 1'($urandom);
      opcode = 7'($urandom);
      br_taken = 1'($urandom);
      step('0, "trap_hold");
    end
  endtask

  task automatic retire(input bit keep);
    m_cnt = (m_cnt + 1) % 16;
    m_idle = !keep;
  endtask

  // One instruction: fw/mw = wait cycles before mem_ready in FETCH/MEM,
  // keep = run level at retirement. lat counts cycles from first FETCH.
  task automatic instr(input logic [6:0] op, input bit tk, input int fw,
                       input int mw, input bit keep, output int lat);
    en_t e;
    bit ld, st, br, nop, jmp, ill;
    lat = 0;
    ld = (op == 7'h03);
    st = (op == 7'h23);
    br = (op == 7'h63);
    nop = (op == 7'h00);
    jmp = (op == 7'h6f) || (op == 7'h67);
    ill = 1'b1;
    foreach (legal[j]) if (legal[j] == op) ill = 1'b0;
    if (m_idle) begin
      run = 1'b0;
      mif.mem_ready = 1'($urandom);
      repeat ($urandom_range(0, 2)) step('0, "idle");
      run = 1'b1;
      step('0, "idle_go");
      m_idle = 1'b0;
    end
    run = 1'b1;
    for (int i = 0; i <= fw; i++) begin
      mif.mem_ready = (i == fw);
      opcode = 7'($urandom);
      e = '0;
      e.req = 1'b1;
      e.ir = (i == fw);
      step(e, "fetch");
      lat++;
      if (i != fw && i == TO - 1) begin
        trap(2'b10);
        return;
      end
    end
    opcode = op;
    run = keep;
    mif.mem_ready = 1'($urandom);
    e = '0;
    e.pcw = nop;
    e.done = nop;
    step(e, "decode");
    lat++;
    if (ill) begin
      trap(2'b01);
      return;
    end
    if (nop) begin
      retire(keep);
      return;
    end
    opcode = 7'($urandom);
    br_taken = tk;
    mif.mem_ready = 1'($urandom);
    e = '0;
    e.pcw = br;
    e.pcs = br && tk;
    e.done = br;
    step(e, "exec");
    lat++;
    if (br) begin
      retire(keep);
      return;
    end
    br_taken = 1'($urandom);
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        mif.mem_ready = (i == mw);
        e = '0;
        e.req = 1'b1;
        e.asel = 1'b1;
        e.we = st;
        e.pcw = st && (i == mw);
        e.done = st && (i == mw);
        step(e, "mem");
        lat++;
        if (i != mw && i == TO - 1) begin
          trap(2'b10);
          return;
        end
      end
      if (st) begin
        retire(keep);
        return;
      end
    end
    mif.mem_ready = 1'($urandom);
    e = '0;
    e.rf = 1'b1;
    e.pcw = 1'b1;
    e.pcs = jmp;
    e.done = 1'b1;
    step(e, "wb");
    lat++;
    retire(keep);
  endtask

  task automatic run_tab(input vec_t v);
    int n;
    bit got;
    logic r_rf, r_pcs, r_pcw;
    logic [1:0] r_c;
    do_reset();
    run = 1'b1;
    mif.mem_ready = 1'b1;
    opcode = v.op;
    br_taken = v.tk;
    @(posedge clk);
    #1;
    n = 0;
    got = 1'b0;
    r_rf = 1'b0;
    r_pcs = 1'b0;
    r_pcw = 1'b0;
    r_c = 2'b00;
    while (!got && n < 12) begin
      n++;
      @(negedge clk);
      if (instr_done || halted) begin
        got = 1'b1;
        r_rf = rf_we;
        r_pcs = pc_sel;
        r_pcw = pc_we;
        r_c = trap_cause;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk({v.nm, "_lat"}, got ? n : 99, v.lat);
    chk({v.nm, "_rf"}, 32'(r_rf), 32'(v.rf));
    chk({v.nm, "_pcsel"}, 32'(r_pcs), 32'(v.pcs));
    chk({v.nm, "_pcwe"}, 32'(r_pcw), 32'(v.cause == 2'b00));
    chk({v.nm, "_cause"}, 32'(r_c), 32'(v.cause));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({v.nm, "_instret"}, 32'(instret), 32'(v.cause == 2'b00));
  endtask

  initial begin
    int lat;
    logic [6:0] op;
    int fw, mw;
    mif.mem_ready = 1'b0;

    tab[0]  = '{"r",      7'h33, 1'b0, 4, 1'b1, 1'b0, 2'b00};
    tab[1]  = '{"ialu",   7'h13, 1'b0, 4, 1'b1, 1'b0, 2'b00};
    tab[2]  = '{"load",   7'h03, 1'b0, 5, 1'b1, 1'b0, 2'b00};
    tab[3]  = '{"store",  7'h23, 1'b0, 4, 1'b0, 1'b0, 2'b00};
    tab[4]  = '{"br_t",   7'h63, 1'b1, 3, 1'b0, 1'b1, 2'b00};
    tab[5]  = '{"br_nt",  7'h63, 1'b0, 3, 1'b0, 1'b0, 2'b00};
    tab[6]  = '{"jal",    7'h6f, 1'b0, 4, 1'b1, 1'b1, 2'b00};
    tab[7]  = '{"jalr",   7'h67, 1'b0, 4, 1'b1, 1'b1, 2'b00};
    tab[8]  = '{"auipc",  7'h17, 1'b0, 4, 1'b1, 1'b0, 2'b00};
    tab[9]  = '{"lui",    7'h37, 1'b0, 4, 1'b1, 1'b0, 2'b00};
    tab[10] = '{"nop",    7'h00, 1'b0, 2, 1'b0, 1'b0, 2'b00};
    tab[11] = '{"illegal",7'h7f, 1'b0, 3, 1'b0, 1'b0, 2'b01};
    foreach (tab[k]) run_tab(tab[k]);

    do_reset();
    instr(7'h03, 1'b0, 0, 3, 1'b1, lat);
    chk("load_wait_lat", lat, 8);

    do_reset();
    instr(7'h33, 1'b0, 20, 0, 1'b1, lat);
    chk("fetch_tmo_lat", lat, TO);
    chk("tmo_halted", 32'(halted), 32'd1);
    chk("tmo_cause", 32'(trap_cause), 32'd2);

    do_reset();
    run = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("req_before_rst", 32'(mif.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("req_async_drop", 32'(mif.mem_req), 32'd0);
    chk("instret_after_rst", 32'(instret), 32'd0);

    do_reset();
    repeat (15) instr(7'h00, 1'b0, 0, 0, 1'b1, lat);
    chk("pre_wrap", 32'(instret), 32'd15);
    instr(7'h6f, 1'b0, 0, 0, 1'b0, lat);
    chk("wrap", 32'(instret), 32'd0);
    run = 1'b0;
    step('0, "idle_hold");
    step('0, "idle_hold");

    do_reset();
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 15) == 0) op = 7'h7f;
      else op = legal[$urandom_range(0, 9)];
      fw = ($urandom_range(0, 19) == 0) ? $urandom_range(16, 18)
                                        : $urandom_range(0, 3);
      mw = ($urandom_range(0, 19) == 0) ? $urandom_range(16, 18)
                                        : $urandom_range(0, 3);
      instr(op, 1'($urandom), fw, mw, $urandom_range(0, 3) != 0, lat);
      if (m_halt) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
